// File: rtl/req_pkg.sv
// ---------------------------------------------------------------------------
// req_pkg
//   Shared constants and types for the request pending latch that sits in
//   front of the 4-to-2 priority encoder.
//
//   Contents:
//     N            number of request lines (matches encoder input width)
//     IDX_W        width of the acknowledge index returned by the encoder
//     SYNC_STAGES  synchroniser depth per request line (>= 2)
//     CNT_W        width of the saturating event counter
//     PC_W         width needed to hold a popcount of N bits
//     req_vec_t    one bit per request line
//     req_idx_t    encoded line index
//     popcount     number of set bits in a req_vec_t
// ---------------------------------------------------------------------------
package req_pkg;

  localparam int N           = 4;
  localparam int IDX_W       = 2;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;
  localparam int PC_W        = $clog2(N + 1);

  typedef logic [N-1:0]     req_vec_t;
  typedef logic [IDX_W-1:0] req_idx_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [PC_W-1:0] popcount(input req_vec_t v);
    logic [PC_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + {{(PC_W-1){1'b0}}, v[i]};
    end
    return acc;
  endfunction

endpackage : req_pkg

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//   Single-bit synchroniser followed by a history flop and a rising-edge
//   detector. The raw input is sampled through STAGES flops; rise_o is high
//   for exactly one clk cycle each time the synchronised level goes 0 -> 1.
//
//   Ports:
//     clk     in   clock
//     rst_n   in   asynchronous active-low reset (all flops to 0)
//     d_i     in   raw asynchronous level
//     rise_o  out  one-cycle pulse on a synchronised rising edge
//
//   All flops reset to 0, so a line already high when reset is released
//   looks like a fresh rising edge and produces one event.
// ---------------------------------------------------------------------------
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              hist_q;
  logic              hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // Edge detection only looks at the last synchroniser stage, which is the
  // first point where the level is guaranteed stable in the clk domain.
  assign rise_o = sync_q[STAGES-1] & ~hist_q;

endmodule : sync_edge_det

// File: rtl/req_pending_latch.sv
// ---------------------------------------------------------------------------
// req_pending_latch
//   Upstream stage of the 4-to-2 priority encoder. Raw request lines are
//   synchronised, rising edges are detected, and each event is held as a
//   sticky pending bit until the encoder's index acknowledges it.
//
//   Ports:
//     clk          in   clock, all state updates on rising edge
//     rst_n        in   asynchronous active-low reset
//     req_i        in   raw asynchronous request levels
//     mask_i       in   per-line enable for recording new edges
//     ack_valid_i  in   acknowledge strobe
//     ack_idx_i    in   line index to acknowledge (encoder output)
//     ovf_clr_i    in   clear all overflow flags
//     pend_o       out  sticky pending bits, drive encoder a[3:0]
//     any_pend_o   out  OR of pending bits, aligned with pend_o
//     ovf_o        out  sticky per-line overflow (event lost) flags
//     ack_err_o    out  one-cycle pulse: ack hit a non-pending line
//     evt_cnt_o    out  saturating count of recorded events
//
//   Acknowledge handshake: ack_valid_i is a strobe with no back-pressure.
//   Every clk edge on which ack_valid_i is high is one acknowledge of line
//   ack_idx_i; it clears that pending bit if set, otherwise it raises
//   ack_err_o on the following cycle and changes nothing else. Back-to-back
//   strobes are independent acknowledges, one line each.
// ---------------------------------------------------------------------------
module req_pending_latch
  import req_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  req_vec_t         req_i,
  input  req_vec_t         mask_i,
  input  logic             ack_valid_i,
  input  req_idx_t         ack_idx_i,
  input  logic             ovf_clr_i,
  output req_vec_t         pend_o,
  output logic             any_pend_o,
  output req_vec_t         ovf_o,
  output logic             ack_err_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  // -------------------------------------------------------------------------
  // Per-line synchroniser and rising-edge detector
  // -------------------------------------------------------------------------
  req_vec_t rise;

  for (genvar gi = 0; gi < N; gi++) begin : g_sync
    sync_edge_det #(
      .STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (req_i[gi]),
      .rise_o (rise[gi])
    );
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  req_vec_t         pend_q,    pend_d;
  req_vec_t         ovf_q,     ovf_d;
  logic             any_q,     any_d;
  logic             ack_err_q, ack_err_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  req_vec_t         set_v;
  req_vec_t         clr_v;
  logic [PC_W-1:0]  set_cnt;
  logic [CNT_W:0]   cnt_sum;

  always_comb begin
    set_v     = '0;
    clr_v     = '0;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    any_d     = any_q;
    ack_err_d = 1'b0;
    set_cnt   = '0;
    cnt_sum   = '0;
    cnt_d     = cnt_q;

    // Mask only gates new events; bits already pending are untouched.
    set_v = rise & mask_i;

    // Only a pending bit can be cleared, and at most one per strobe.
    if (ack_valid_i) begin
      clr_v[ack_idx_i] = pend_q[ack_idx_i];
    end

    // set wins over clr: when both hit the same line the ack consumes the
    // old event and the new one stays pending, so nothing is lost.
    pend_d = set_v | (pend_q & ~clr_v);

    // An event is lost only when it arrives on an already pending line that
    // is not being acknowledged this cycle. A loss in the same cycle as
    // ovf_clr_i still leaves the flag set.
    ovf_d = (ovf_clr_i ? '0 : ovf_q) | (set_v & pend_q & ~clr_v);

    any_d = |pend_d;

    ack_err_d = ack_valid_i & ~pend_q[ack_idx_i];

    // One spare bit on the sum catches the carry out for saturation.
    set_cnt = popcount(set_v);
    cnt_sum = {1'b0, cnt_q} + {{(CNT_W+1-PC_W){1'b0}}, set_cnt};
    cnt_d   = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      ovf_q     <= '0;
      any_q     <= 1'b0;
      ack_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      any_q     <= any_d;
      ack_err_q <= ack_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign any_pend_o = any_q;
  assign ovf_o      = ovf_q;
  assign ack_err_o  = ack_err_q;
  assign evt_cnt_o  = cnt_q;

endmodule : req_pending_latch

// File: doc/req_pending_latch.md
Name: req_pending_latch

Overview:
- Upstream stage of the 4-to-2 priority encoder.
- Takes four asynchronous raw request lines and synchronises them into clk, then detects rising edges.
- Holds each event as a sticky pending bit until acknowledged by encoded index.
- pend_o[3:0] drives the encoder's a[3:0]; the encoder's y[1:0] returns as ack_idx_i, closing the loop.

Parameters:
- N, 4, number of request lines; fixed at 4 to match the encoder width.
- IDX_W, 2, width of the acknowledge index (log2 N).
- SYNC_STAGES, 2, synchroniser flop depth per request line; minimum 2.
- CNT_W, 8, width of the saturating event counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_i  input  N  raw asynchronous request lines, level-high.
- mask_i  input  N  per-line enable; 1 = edges recorded, 0 = edges discarded.
- ack_valid_i  input  1  one-cycle strobe: clear the pending bit selected by ack_idx_i.
- ack_idx_i  input  IDX_W  index of the bit to clear (encoder output).
- ovf_clr_i  input  1  clears all overflow flags.
- pend_o  output  N  registered sticky pending bits; feeds encoder a[3:0].
- any_pend_o  output  1  registered OR of pending bits.
- ovf_o  output  N  sticky per-line overflow flags.
- ack_err_o  output  1  one-cycle pulse: ack targeted a non-pending bit.
- evt_cnt_o  output  CNT_W  count of recorded events, saturating.

Behaviour:
- Reset (rst_n=0, async): all synchroniser flops, edge-history flops, pend_o, any_pend_o, ovf_o, ack_err_o and evt_cnt_o go to 0.
- Because the synchroniser resets to 0, a req_i line held high through reset release produces exactly one event.
- Synchroniser: per line, SYNC_STAGES flops, plus one history flop.
- Rise detect: rise[i] = s_last[i] & ~s_hist[i].
- Latency: req_i rising before clock edge k gives pend_o[i]=1 after edge k+SYNC_STAGES. That is 3 edges for the default; the first sampling edge counts.
- set[i] = rise[i] & mask_i[i]. mask_i gates new events only; pending bits already set stay until acked.
- clr[i] = ack_valid_i & (ack_idx_i == i) & pend_o[i].
- Next-state rules, evaluated per bit i in the same cycle:
  - set and clr both true: pend stays 1, ovf unchanged. The ack consumed the old event and the new event is held.
  - set only, with pend=0: pend <- 1.
  - set only, with pend=1: pend stays 1, ovf[i] <- 1 (event lost).
  - clr only: pend <- 0.
- ack_err_o = ack_valid_i & ~pend_o[ack_idx_i], registered; one cycle after the strobe. No state change on error.
- At most one bit is cleared per ack; ack_valid_i on consecutive cycles is legal.
- ovf_clr_i clears all ovf bits. If an overflow occurs in the same cycle as ovf_clr_i, the set wins: the bit ends 1.
- evt_cnt_o increments by popcount(set) each cycle (0..4), saturates at 2^CNT_W-1, and never wraps.
- any_pend_o is registered from next-state pend, so it is coincident with pend_o.
- Pulses on req_i shorter than one clk period may be missed; this is acceptable.
- Glitch-free edge detection is guaranteed only post-synchroniser.

Decomposition:
- Package req_pkg holds:
  - constants N=4, IDX_W=2, SYNC_STAGES=2, CNT_W=8;
  - typedef req_vec_t (logic [N-1:0]);
  - typedef req_idx_t (logic [IDX_W-1:0]).
- One sub-module, sync_edge_det: a single-bit synchroniser plus history flop that outputs rise. It is instantiated N times via generate.
- Top holds the pending, overflow and counter logic.

Test Plan:
- Reset release with req_i=4'b0000, mask_i=4'b1111 -> pend_o=0, ovf_o=0, evt_cnt_o=0; nothing changes for 10 cycles.
- req_i=4'b1000 rising before edge k -> pend_o=4'b1000 and any_pend_o=1 after edge k+2; evt_cnt_o=1. Then ack_valid_i=1, ack_idx_i=2'd3 -> pend_o=0 next edge.
- req_i 4'b0000->4'b0110 in one step -> pend_o=4'b0110, evt_cnt_o=2. Ack idx 2 then idx 1 on consecutive cycles -> pend_o goes 4'b0010, then 4'b0000.
- bit0 pending; deassert then reassert req_i[0] before ack -> ovf_o=4'b0001, pend_o[0] stays 1. A new rise landing on the same cycle as the ack for idx 0 -> pend_o[0]=1, ovf unchanged.
- mask_i=4'b1011 with a rise on req_i[2] -> pend_o[2] stays 0, evt_cnt_o unchanged. Ack idx 2 -> ack_err_o pulses 1 for one cycle.
- Drive 300 events -> evt_cnt_o=8'hFF and holds. Assert rst_n=0 mid-run with pend_o=4'b1111 -> all outputs 0 immediately, without waiting for clk.
